processor: RTL and testbench
============================

PROCESSOR -- requirements
Module: processor

Interface
REQ-001 Parameter IMEM_WORDS, default 64: number of 32-bit words in the instruction ROM.
REQ-002 Parameter DMEM_WORDS, default 64: number of 32-bit words in the data RAM.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: reset is synchronous and active-high.
REQ-005 Port Result, output, 32: combinational ALU result of the instruction currently at PC.

Function
REQ-006 The processor SHALL be a single-cycle RV32 subset with these state elements:
- PC, 32 bits
- register file x0..x31, 32 bits each; x0 reads 0 and ignores writes
- instruction ROM, word-indexed by PC[7:2]
- data RAM, word-indexed by address[7:2]
REQ-007 Each rising clk with reset=0 SHALL execute one instruction: PC <= PC+4, with register/RAM write-back at the same edge; no branches or jumps.
REQ-008 Supported R-type instructions (opcode 0110011) SHALL be:
- add (f3 000, f7 0000000), sub (000/0100000)
- and (111/0000000), or (110/0000000)
- slt signed (010/0000000)
- nor = ~(rs1|rs2) (100/0100000)
REQ-009 Supported I-type instructions (opcode 0010011) SHALL be addi (000), andi (111), ori (110), slti (010); the 12-bit immediate is sign-extended.
REQ-010 lw (opcode 0000011, f3 010) SHALL write rd <= RAM[rs1+imm]; sw (opcode 0100011, f3 010) SHALL write RAM[rs1+S-imm] <= rs2.
REQ-011 For every instruction Result SHALL equal the ALU output; for lw/sw this is the effective address, not the memory data.
REQ-012 Any unsupported encoding, including 0x00000000, SHALL be a NOP: no register or RAM write, Result=0, PC still advances.
REQ-013 Arithmetic SHALL be 32-bit modulo 2^32 with no overflow flag; slt/slti compare signed and give 1 or 0.
REQ-014 The PC SHALL wrap modulo IMEM_WORDS*4; RAM addresses SHALL use bits [7:2] only, with low bits ignored.
REQ-015 The instruction ROM SHALL be preloaded with this program at word 0..20; all other words are 0:
- and x20,x0,x0
- addi x1,x0,1; addi x2,x0,2; addi x3,x0,4; addi x4,x0,5; addi x5,x0,7; addi x6,x0,8; addi x7,x0,11
- add x8,x1,x2; sub x9,x2,x3; and x10,x2,x4; or x11,x1,x3; slt x12,x1,x2; nor x13,x7,x0
- andi x14,x9,0x4D2; ori x15,x4,-1833; slt x16,x9,x1; nor x17,x14,x1
- sw x8,48(x0); lw x18,48(x0); lw x19,48(x0)

Reset
REQ-016 A rising clk with reset=1 SHALL set PC to 0 and clear all registers to 0; data RAM contents are unaffected.
REQ-017 While reset=1, Result SHALL reflect the instruction at PC 0, which gives 0.
REQ-018 Reset asserted mid-program SHALL restart execution from word 0 on the next edge, with the registers zeroed.

Verification
REQ-019 Reset for one edge, then release -> on successive cycles Result = 0, 1, 2, 4, 5, 7, 8, 0xB.
REQ-020 Continuing, the R-type block -> Result = 3, 0xFFFFFFFE, 0, 5, 1, 0xFFFFFFF4.
REQ-021 Continuing, the immediate/NOR block -> Result = 0x4D2, 0xFFFFF8D7, 1, 0xFFFFFB2C.
REQ-022 Continuing, the memory block -> Result = 0x30, 0x30, 0x30; afterwards x18 = x19 = 3 and RAM word 12 = 3.
REQ-023 After word 20 executes -> Result = 0 (NOP region) and no register changes.
REQ-024 Reset asserted at cycle 10, then released -> the sequence restarts at Result = 0, 1, 2, ... exactly as in REQ-019.

Source files
------------

// File: rtl/processor.sv
// Single-cycle RV32 subset core with a built-in program ROM and a small data RAM.
// One instruction executes per rising clock edge; there are no branches or jumps.
// Result presents the ALU output of the instruction currently addressed by the PC.
// For loads and stores that output is the effective address. Unsupported
// encodings, including the all-zero word, behave as NOPs and drive Result to 0.
module processor #(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] Result
);

    localparam int          IA         = $clog2(IMEM_WORDS);
    localparam int          DA         = $clog2(DMEM_WORDS);
    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_NOR = 3'd5;

    // Instruction encoders. They keep the ROM table below readable as assembly.
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
    endfunction

    // Program ROM. Every word outside the listed program reads as 0, which decodes as a NOP.
    function automatic logic [31:0] rom_word(input logic [IA-1:0] idx);
        logic [31:0] w;
        case (int'(idx))
            0:  w = enc_r(F7_BASE, 3'b111, 5'd20, 5'd0, 5'd0);      // and  x20,x0,x0
            1:  w = enc_i(OP_I, 3'b000, 5'd1, 5'd0, 12'd1);         // addi x1,x0,1
            2:  w = enc_i(OP_I, 3'b000, 5'd2, 5'd0, 12'd2);         // addi x2,x0,2
            3:  w = enc_i(OP_I, 3'b000, 5'd3, 5'd0, 12'd4);         // addi x3,x0,4
            4:  w = enc_i(OP_I, 3'b000, 5'd4, 5'd0, 12'd5);         // addi x4,x0,5
            5:  w = enc_i(OP_I, 3'b000, 5'd5, 5'd0, 12'd7);         // addi x5,x0,7
            6:  w = enc_i(OP_I, 3'b000, 5'd6, 5'd0, 12'd8);         // addi x6,x0,8
            7:  w = enc_i(OP_I, 3'b000, 5'd7, 5'd0, 12'd11);        // addi x7,x0,11
            8:  w = enc_r(F7_BASE, 3'b000, 5'd8, 5'd1, 5'd2);       // add  x8,x1,x2
            9:  w = enc_r(F7_ALT,  3'b000, 5'd9, 5'd2, 5'd3);       // sub  x9,x2,x3
            10: w = enc_r(F7_BASE, 3'b111, 5'd10, 5'd2, 5'd4);      // and  x10,x2,x4
            11: w = enc_r(F7_BASE, 3'b110, 5'd11, 5'd1, 5'd3);      // or   x11,x1,x3
            12: w = enc_r(F7_BASE, 3'b010, 5'd12, 5'd1, 5'd2);      // slt  x12,x1,x2
            13: w = enc_r(F7_ALT,  3'b100, 5'd13, 5'd7, 5'd0);      // nor  x13,x7,x0
            14: w = enc_i(OP_I, 3'b111, 5'd14, 5'd9, 12'h4D2);      // andi x14,x9,0x4D2
            15: w = enc_i(OP_I, 3'b110, 5'd15, 5'd4, 12'h8D7);      // ori  x15,x4,-1833
            16: w = enc_r(F7_BASE, 3'b010, 5'd16, 5'd9, 5'd1);      // slt  x16,x9,x1
            17: w = enc_r(F7_ALT,  3'b100, 5'd17, 5'd14, 5'd1);     // nor  x17,x14,x1
            18: w = enc_s(5'd8, 5'd0, 12'd48);                      // sw   x8,48(x0)
            19: w = enc_i(OP_LOAD, 3'b010, 5'd18, 5'd0, 12'd48);    // lw   x18,48(x0)
            20: w = enc_i(OP_LOAD, 3'b010, 5'd19, 5'd0, 12'd48);    // lw   x19,48(x0)
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    logic [31:0] r_pc;
    logic [31:0] r_regs [0:31];
    logic [31:0] r_dmem [0:DMEM_WORDS-1];

    logic [31:0]   w_fetch_pc;
    logic [IA-1:0] w_imem_idx;
    logic [31:0]   w_instr;
    logic [6:0]    w_opcode;
    logic [2:0]    w_f3;
    logic [6:0]    w_f7;
    logic [4:0]    w_rd;
    logic [4:0]    w_rs1;
    logic [4:0]    w_rs2;
    logic [31:0]   w_imm_i;
    logic [31:0]   w_imm_s;
    logic [31:0]   w_rs1_val;
    logic [31:0]   w_rs2_val;

    logic          w_valid;
    logic [2:0]    w_alu_sel;
    logic          w_use_imm;
    logic [31:0]   w_imm;
    logic          w_reg_we;
    logic          w_mem_we;
    logic          w_mem_to_reg;

    logic [31:0]   w_alu_b;
    logic [31:0]   w_alu_y;
    logic [DA-1:0] w_dmem_idx;
    logic [31:0]   w_load_data;
    logic [31:0]   w_wb_data;
    logic [31:0]   w_pc_plus4;

    // While reset is held, fetch from word 0 so Result already shows the first instruction.
    assign w_fetch_pc = reset ? 32'd0 : r_pc;
    assign w_imem_idx = w_fetch_pc[IA+1:2];
    assign w_instr    = rom_word(w_imem_idx);

    assign w_opcode = w_instr[6:0];
    assign w_rd     = w_instr[11:7];
    assign w_f3     = w_instr[14:12];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_f7     = w_instr[31:25];
    assign w_imm_i  = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s  = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};

    // x0 is hard-wired to zero regardless of what the array holds.
    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

    // Decode: any encoding not matched exactly leaves w_valid low, so it executes as a NOP.
    always_comb begin
        w_valid      = 1'b0;
        w_alu_sel    = ALU_ADD;
        w_use_imm    = 1'b0;
        w_imm        = w_imm_i;
        w_reg_we     = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_to_reg = 1'b0;
        case (w_opcode)
            OP_R: begin
                case ({w_f7, w_f3})
                    {F7_BASE, 3'b000}: begin w_valid = 1'b1; w_alu_sel = ALU_ADD; end
                    {F7_ALT,  3'b000}: begin w_valid = 1'b1; w_alu_sel = ALU_SUB; end
                    {F7_BASE, 3'b111}: begin w_valid = 1'b1; w_alu_sel = ALU_AND; end
                    {F7_BASE, 3'b110}: begin w_valid = 1'b1; w_alu_sel = ALU_OR;  end
                    {F7_BASE, 3'b010}: begin w_valid = 1'b1; w_alu_sel = ALU_SLT; end
                    {F7_ALT,  3'b100}: begin w_valid = 1'b1; w_alu_sel = ALU_NOR; end
                    default: ;
                endcase
                w_reg_we = w_valid;
            end
            OP_I: begin
                w_use_imm = 1'b1;
                case (w_f3)
                    3'b000: begin w_valid = 1'b1; w_alu_sel = ALU_ADD; end
                    3'b111: begin w_valid = 1'b1; w_alu_sel = ALU_AND; end
                    3'b110: begin w_valid = 1'b1; w_alu_sel = ALU_OR;  end
                    3'b010: begin w_valid = 1'b1; w_alu_sel = ALU_SLT; end
                    default: ;
                endcase
                w_reg_we = w_valid;
            end
            OP_LOAD: begin
                if (w_f3 == 3'b010) begin
                    w_valid      = 1'b1;
                    w_use_imm    = 1'b1;
                    w_reg_we     = 1'b1;
                    w_mem_to_reg = 1'b1;
                end
            end
            OP_STORE: begin
                if (w_f3 == 3'b010) begin
                    w_valid   = 1'b1;
                    w_use_imm = 1'b1;
                    w_imm     = w_imm_s;
                    w_mem_we  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign w_alu_b = w_use_imm ? w_imm : w_rs2_val;

    // ALU: modulo-2^32 arithmetic, signed compare for slt/slti.
    always_comb begin
        case (w_alu_sel)
            ALU_ADD: w_alu_y = w_rs1_val + w_alu_b;
            ALU_SUB: w_alu_y = w_rs1_val - w_alu_b;
            ALU_AND: w_alu_y = w_rs1_val & w_alu_b;
            ALU_OR:  w_alu_y = w_rs1_val | w_alu_b;
            ALU_SLT: w_alu_y = {31'd0, ($signed(w_rs1_val) < $signed(w_alu_b))};
            ALU_NOR: w_alu_y = ~(w_rs1_val | w_alu_b);
            default: w_alu_y = 32'd0;
        endcase
    end

    assign Result = w_valid ? w_alu_y : 32'd0;

    // The data RAM is word addressed. Low address bits and bits above the RAM range are ignored.
    assign w_dmem_idx  = w_alu_y[DA+1:2];
    assign w_load_data = r_dmem[w_dmem_idx];
    assign w_wb_data   = w_mem_to_reg ? w_load_data : w_alu_y;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Bits that no logic consumes are collected here on purpose.
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, r_pc[31:IA+2], r_pc[1:0], w_alu_y[31:DA+2], w_alu_y[1:0]};

    // Program counter: advance one word per edge, wrapping at the end of the ROM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= 32'd0;
        end else if (w_pc_plus4 >= IMEM_BYTES) begin
            r_pc <= 32'd0;
        end else begin
            r_pc <= w_pc_plus4;
        end
    end

    // Register file: cleared on reset, write-back at the executing edge, x0 never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_reg_we && (w_rd != 5'd0)) begin
            r_regs[w_rd] <= w_wb_data;
        end
    end

    // Data RAM store. Contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && w_mem_we) begin
            r_dmem[w_dmem_idx] <= w_rs2_val;
        end
    end

endmodule

// File: tb/tb_processor.sv
// Directed bench for the single-cycle processor: the program's Result trace,
// architectural state after the program, the NOP region, PC wrap, and a mid-program reset.
module tb_processor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Result;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] prog_exp [0:20];

    processor #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
        .clk    (clk),
        .reset  (reset),
        .Result (Result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    task automatic chk_pop(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s observed=%08h expected=<empty queue>", tag, Result);
        end else begin
            e = exp_q.pop_front();
            chk(tag, Result, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        prog_exp = '{32'h0, 32'h1, 32'h2, 32'h4, 32'h5, 32'h7, 32'h8, 32'hB,
                     32'h3, 32'hFFFF_FFFE, 32'h0, 32'h5, 32'h1, 32'hFFFF_FFF4,
                     32'h4D2, 32'hFFFF_F8D7, 32'h1, 32'hFFFF_FB2C,
                     32'h30, 32'h30, 32'h30};

        // Initial reset: Result shows word 0 while reset is held.
        reset = 1'b1;
        tick();
        tick();
        chk("reset_result", Result, 32'h0);
        chk("reset_pc", dut.r_pc, 32'h0);
        chk("reset_x1", dut.r_regs[1], 32'h0);

        // Run the whole program.
        reset = 1'b0;
        for (int i = 0; i < 21; i++) exp_q.push_back(prog_exp[i]);
        for (int i = 0; i < 21; i++) begin
            chk_pop($sformatf("prog_w%0d", i));
            tick();
        end

        // Architectural state after word 20.
        chk("x8",  dut.r_regs[8],  32'h3);
        chk("x9",  dut.r_regs[9],  32'hFFFF_FFFE);
        chk("x13", dut.r_regs[13], 32'hFFFF_FFF4);
        chk("x15", dut.r_regs[15], 32'hFFFF_F8D7);
        chk("x17", dut.r_regs[17], 32'hFFFF_FB2C);
        chk("x18", dut.r_regs[18], 32'h3);
        chk("x19", dut.r_regs[19], 32'h3);
        chk("x20", dut.r_regs[20], 32'h0);
        chk("ram12", dut.r_dmem[12], 32'h3);

        // NOP region: Result is 0 and registers do not change.
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < 4; i++) begin
            chk_pop($sformatf("nop_w%0d", 21 + i));
            tick();
        end
        chk("nop_x17", dut.r_regs[17], 32'hFFFF_FB2C);
        chk("nop_x19", dut.r_regs[19], 32'h3);
        chk("nop_x0",  dut.r_regs[0],  32'h0);

        // Run through to the PC wrap, bounded.
        for (int c = 0; c < 100 && dut.r_pc != 32'h0; c++) tick();
        chk("wrap_pc", dut.r_pc, 32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h2);
        for (int i = 0; i < 3; i++) begin
            chk_pop($sformatf("wrap_w%0d", i));
            tick();
        end

        // Advance to cycle 10, then reset for one edge.
        for (int i = 0; i < 7; i++) tick();
        chk("pre_rst_pc", dut.r_pc, 32'd40);
        reset = 1'b1;
        tick();
        chk("midrst_pc", dut.r_pc, 32'h0);
        chk("midrst_x1", dut.r_regs[1], 32'h0);
        chk("midrst_x8", dut.r_regs[8], 32'h0);
        chk("midrst_ram12", dut.r_dmem[12], 32'h3);
        chk("midrst_result", Result, 32'h0);

        reset = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(prog_exp[i]);
        for (int i = 0; i < 8; i++) begin
            chk_pop($sformatf("restart_w%0d", i));
            tick();
        end
        chk("restart_x7", dut.r_regs[7], 32'hB);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
